// File: rtl/audio_sample_sched_pkg.sv
// audio_pkg: shared types and constants for the audio sample scheduler.
// Holds the scheduler FSM state type, divider width and default compare,
// the divisor shift, the frame-count wrap value and the watchdog limit.
package audio_pkg;

   // Divider counter width
   localparam int CNT_W = 24;

   // div_sel is scaled by 2^DIV_SHIFT to form the compare value
   localparam int DIV_SHIFT = 4;

   // Compare used when div_sel == 0 (208-cycle period, 48 kHz at 10 MHz)
   localparam logic [CNT_W-1:0] DIV_DEFAULT = 24'd207;

   // Last value of the activity digit before it wraps to 0
   localparam logic [3:0] FRAME_WRAP = 4'd9;

   // Watchdog limit for the wait states (only used with AUDIO_SCHED_WDOG_EN)
   localparam logic [15:0] WDOG_CYC = 16'd4095;

   // Scheduler states: one start/wait pair per channel
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START_L = 3'd1,
      ST_WAIT_L  = 3'd2,
      ST_START_R = 3'd3,
      ST_WAIT_R  = 3'd4
   } sched_state_t;

   // Next value of the mod-10 frame counter
   function automatic logic [3:0] frame_inc(input logic [3:0] cnt);
      return (cnt >= FRAME_WRAP) ? 4'd0 : cnt + 4'd1;
   endfunction

endpackage

// File: rtl/audio_sample_sched_if.sv
// audio_sample_sched_if: start/busy/done handshake to the shared serial
// converter. The scheduler is the master (issues start and channel), the
// converter is the slave (reports busy and a one-cycle done pulse).
interface audio_sample_sched_if;

   logic ser_start;   // start request, held until accepted
   logic ser_chan;    // 0 = left, 1 = right
   logic ser_busy;    // converter occupied, start not accepted
   logic ser_done;    // one-cycle pulse at end of transfer

   modport master (
      output ser_start,
      output ser_chan,
      input  ser_busy,
      input  ser_done
   );

   modport slave (
      input  ser_start,
      input  ser_chan,
      output ser_busy,
      output ser_done
   );

endinterface

// File: rtl/audio_sample_sched_tick_gen.sv
// sample_tick_gen: programmable sample-rate divider.
// Counts clk cycles and strobes sample_tick when the count reaches the
// selected compare value; the period is compare+1 cycles. A compare that
// drops below the running count fires on the same cycle.
module sample_tick_gen
   import audio_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] div_sel,
   output logic       sample_tick
);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic [CNT_W-1:0] compare;
   logic             tick;

   // Select the compare value: default rate, or div_sel scaled by 16
   always_comb begin
      compare = DIV_DEFAULT;
      if (div_sel != 8'd0)
         compare = CNT_W'({div_sel, {DIV_SHIFT{1'b0}}});
   end

   // Greater-or-equal so a lowered compare fires at once instead of wrapping
   assign tick = enable && !reset && (count_reg >= compare);

   // Next count: cleared while disabled or after a tick, otherwise increments
   always_comb begin
      count_next = count_reg + CNT_W'(1);
      if (!enable || tick)
         count_next = '0;
   end

   // Divider counter register
   always_ff @(posedge clk) begin
      if (reset)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

   assign sample_tick = tick;

endmodule

// File: rtl/audio_sample_sched.sv
// audio_sample_sched: audio frame scheduler.
// Each sample tick runs a left then a right transfer on the shared serial
// converter, counts completed frames mod 10 and flags dropped ticks.
// Optional watchdog on the wait states: define AUDIO_SCHED_WDOG_EN.
module audio_sample_sched
   import audio_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [7:0]           div_sel,
   input  logic                 overrun_clr,
   audio_sample_sched_if.master ser,
   output logic                 sample_tick,
   output logic                 overrun,
   output logic                 wdog_err,
   output logic [3:0]           frame_cnt
);

   sched_state_t state_reg;
   logic         ser_start_reg;
   logic         ser_chan_reg;
   logic         overrun_reg;
   logic [3:0]   frame_cnt_reg;
   logic         tick_drop;

   sample_tick_gen u_tick_gen (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .div_sel     (div_sel),
      .sample_tick (sample_tick)
   );

   // A tick that arrives while a frame is still in flight is dropped
   assign tick_drop = sample_tick && (state_reg != ST_IDLE);

`ifdef AUDIO_SCHED_WDOG_EN
   logic [15:0] wdog_cnt_reg;
   logic        wdog_err_reg;
   logic        wdog_expired;

   assign wdog_expired = (wdog_cnt_reg == WDOG_CYC);

   // Cycles spent in the current wait state; restarts at 0 on every entry
   always_ff @(posedge clk) begin
      if (reset || !((state_reg == ST_WAIT_L) || (state_reg == ST_WAIT_R)))
         wdog_cnt_reg <= '0;
      else
         wdog_cnt_reg <= wdog_cnt_reg + 16'd1;
   end

   assign wdog_err = wdog_err_reg;
`else
   assign wdog_err = 1'b0;
`endif

   // Frame sequencer: start/wait per channel, outputs registered with the state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         ser_start_reg <= 1'b0;
         ser_chan_reg  <= 1'b0;
         frame_cnt_reg <= 4'd0;
`ifdef AUDIO_SCHED_WDOG_EN
         wdog_err_reg  <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (sample_tick) begin
                  state_reg     <= ST_START_L;
                  ser_start_reg <= 1'b1;
                  ser_chan_reg  <= 1'b0;
               end
            end
            ST_START_L: begin
               if (!ser.ser_busy) begin
                  state_reg     <= ST_WAIT_L;
                  ser_start_reg <= 1'b0;
               end
            end
            ST_WAIT_L: begin
               if (ser.ser_done) begin
                  state_reg     <= ST_START_R;
                  ser_start_reg <= 1'b1;
                  ser_chan_reg  <= 1'b1;
               end
`ifdef AUDIO_SCHED_WDOG_EN
               else if (wdog_expired) begin
                  state_reg     <= ST_IDLE;
                  ser_chan_reg  <= 1'b0;
                  wdog_err_reg  <= 1'b1;
               end
`endif
            end
            ST_START_R: begin
               if (!ser.ser_busy) begin
                  state_reg     <= ST_WAIT_R;
                  ser_start_reg <= 1'b0;
               end
            end
            ST_WAIT_R: begin
               if (ser.ser_done) begin
                  state_reg     <= ST_IDLE;
                  ser_chan_reg  <= 1'b0;
                  frame_cnt_reg <= frame_inc(frame_cnt_reg);
               end
`ifdef AUDIO_SCHED_WDOG_EN
               else if (wdog_expired) begin
                  state_reg     <= ST_IDLE;
                  ser_chan_reg  <= 1'b0;
                  wdog_err_reg  <= 1'b1;
               end
`endif
            end
            default: begin
               state_reg     <= ST_IDLE;
               ser_start_reg <= 1'b0;
               ser_chan_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overrun flag; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk) begin
      if (reset)
         overrun_reg <= 1'b0;
      else if (tick_drop)
         overrun_reg <= 1'b1;
      else if (overrun_clr)
         overrun_reg <= 1'b0;
   end

   assign ser.ser_start = ser_start_reg;
   assign ser.ser_chan  = ser_chan_reg;
   assign overrun       = overrun_reg;
   assign frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_audio_sample_sched.sv
// tb_audio_sample_sched: self-checking bench for audio_sample_sched.
// A serializer responder drives busy/done; a transaction-level reference
// model predicts tick, start/channel, frame count and flags every cycle.
module tb_audio_sample_sched;
   import audio_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       overrun_clr = 1'b0;
   logic [7:0] div_sel = 8'd0;
   logic       sample_tick;
   logic       overrun;
   logic       wdog_err;
   logic [3:0] frame_cnt;

   audio_sample_sched_if ser_if ();

   audio_sample_sched dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .div_sel     (div_sel),
      .overrun_clr (overrun_clr),
      .ser         (ser_if),
      .sample_tick (sample_tick),
      .overrun     (overrun),
      .wdog_err    (wdog_err),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Inputs requested for the next cycle
   logic       nx_reset = 1'b1;
   logic       nx_enable = 1'b0;
   logic       nx_clr = 1'b0;
   logic [7:0] nx_div = 8'd0;

   // Serializer responder
   int xfer_cnt   = -1;
   int stall_left = 0;
   int stall_cfg  = 0;
   int done_delay = 8;
   bit rand_ser   = 1'b0;
   bit prev_start = 1'b0;

   // Reference model: expected registered outputs for the next cycle
   int anchor     = 1;      // cycle at which the divider count was 0
   bit m_busy     = 1'b0;   // frame in progress
   bit m_start    = 1'b0;
   bit m_chan     = 1'b0;
   bit m_ovr      = 1'b0;
   bit m_wdog     = 1'b0;
   int m_frames   = 0;
   int wait_start = 0;

   // Observed-event bookkeeping for directed checks
   int   tick_cnt  = 0;
   int   last_tick = 0;
   int   tick_gap  = 0;
   int   run_len   = 0;
   int   last_run  = 0;
   bit   saw_wrap  = 1'b0;
   bit   prev_rst  = 1'b1;
   logic [3:0] prev_fc = 4'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: apply inputs, run responder, check, advance model
   task automatic step();
      int cmp;
      bit e_tick;
      bit busy_old;
      @(posedge clk);
      #1;
      cyc++;
      reset       = nx_reset;
      enable      = nx_enable;
      div_sel     = nx_div;
      overrun_clr = nx_clr;

      ser_if.ser_done = 1'b0;
      if (reset) begin
         xfer_cnt   = -1;
         stall_left = 0;
      end
      if (xfer_cnt > 0) xfer_cnt--;
      if (xfer_cnt == 0) begin
         ser_if.ser_done = 1'b1;
         xfer_cnt = -1;
      end
      if (ser_if.ser_start && !prev_start)
         stall_left = rand_ser ? int'($urandom_range(0, 3)) : stall_cfg;
      prev_start = ser_if.ser_start;
      ser_if.ser_busy = (xfer_cnt > 0) || (ser_if.ser_start && stall_left > 0);
      if (ser_if.ser_start && stall_left > 0) stall_left--;

      @(negedge clk);
      cmp    = (div_sel == 8'd0) ? 207 : int'(div_sel) * 16;
      e_tick = !reset && enable && ((cyc - anchor) >= cmp);
      chk("sample_tick", sample_tick, e_tick);
      chk("ser_start", ser_if.ser_start, m_start);
      chk("ser_chan", ser_if.ser_chan, m_chan);
      chk("frame_cnt", frame_cnt, m_frames);
      chk("overrun", overrun, m_ovr);
      chk("wdog_err", wdog_err, m_wdog);

      if (sample_tick) begin
         tick_gap  = cyc - last_tick;
         last_tick = cyc;
         tick_cnt++;
      end
      if (ser_if.ser_start) run_len++;
      else if (run_len != 0) begin
         last_run = run_len;
         run_len  = 0;
      end
      if (!prev_rst && prev_fc == 4'd9 && frame_cnt == 4'd0) saw_wrap = 1'b1;
      prev_fc  = frame_cnt;
      prev_rst = reset;

      if (!reset && ser_if.ser_start && !ser_if.ser_busy) begin
         xfer_cnt = rand_ser ? int'($urandom_range(1, 40)) : done_delay;
         $display("xfer cyc=%0d chan=%0d frame_cnt=%0d", cyc, ser_if.ser_chan, frame_cnt);
      end

      if (reset) begin
         anchor  = cyc + 1;
         m_busy  = 1'b0;
         m_start = 1'b0;
         m_chan  = 1'b0;
         m_ovr   = 1'b0;
         m_wdog  = 1'b0;
         m_frames = 0;
      end else begin
         busy_old = m_busy;
         if (!enable || e_tick) anchor = cyc + 1;
         if (m_start) begin
            if (!ser_if.ser_busy) begin
               m_start    = 1'b0;
               wait_start = cyc + 1;
            end
         end else if (m_busy) begin
            if (ser_if.ser_done) begin
               if (!m_chan) begin
                  m_start = 1'b1;
                  m_chan  = 1'b1;
               end else begin
                  m_busy   = 1'b0;
                  m_chan   = 1'b0;
                  m_frames = (m_frames + 1) % 10;
               end
            end
`ifdef AUDIO_SCHED_WDOG_EN
            else if ((cyc - wait_start) == int'(WDOG_CYC)) begin
               m_busy = 1'b0;
               m_chan = 1'b0;
               m_wdog = 1'b1;
            end
`endif
         end
         if (e_tick && !busy_old) begin
            m_busy  = 1'b1;
            m_start = 1'b1;
            m_chan  = 1'b0;
         end
         m_ovr = (e_tick && busy_old) ? 1'b1 : (overrun_clr ? 1'b0 : m_ovr);
      end
   endtask

   function automatic bit tick_next();
      int cmp;
      cmp = (nx_div == 8'd0) ? 207 : int'(nx_div) * 16;
      return nx_enable && !nx_reset && ((cyc + 1 - anchor) >= cmp);
   endfunction

   initial begin
      int rel;
      int t0;
      int fc0;
      ser_if.ser_busy = 1'b0;
      ser_if.ser_done = 1'b0;

      // Reset, then default rate
      nx_enable = 1'b1;
      repeat (3) step();
      nx_reset = 1'b0;
      step();
      rel = cyc;
      for (int i = 0; i < 300 && tick_cnt == 0; i++) step();
      chk("first_tick_latency", last_tick - rel, 207);
      for (int i = 0; i < 300 && tick_cnt < 2; i++) step();
      chk("default_period", tick_gap, 208);

      // Full frame at compare 32
      nx_div = 8'd2;
      fc0 = int'(frame_cnt);
      for (int i = 0; i < 400 && int'(frame_cnt) == fc0; i++) step();
      chk("frame_inc", frame_cnt, (fc0 + 1) % 10);
      chk("frame_no_overrun", overrun, 0);

      // Busy stall of 5 cycles holds start for 6
      for (int i = 0; i < 100 && ser_if.ser_start; i++) step();
      stall_cfg = 5;
      last_run  = 0;
      for (int i = 0; i < 200 && last_run == 0; i++) step();
      chk("stall_start_len", last_run, 6);
      stall_cfg = 0;

      // Overrun at 17-cycle period with slow serializer
      nx_div = 8'd1;
      done_delay = 20;
      for (int i = 0; i < 200 && overrun !== 1'b1; i++) step();
      chk("overrun_set", overrun, 1);
      for (int i = 0; i < 50 && tick_next(); i++) step();
      nx_clr = 1'b1;
      step();
      nx_clr = 1'b0;
      step();
      chk("overrun_clr_quiet", overrun, 0);
      for (int i = 0; i < 200 && !(tick_next() && m_busy); i++) step();
      nx_clr = 1'b1;
      step();
      nx_clr = 1'b0;
      step();
      chk("overrun_clr_on_drop", overrun, 1);

      // Enable falls mid-frame: frame finishes, no further ticks
      nx_div = 8'd2;
      done_delay = 10;
      for (int i = 0; i < 300 && (!m_busy || m_start || m_chan); i++) step();
      fc0 = int'(frame_cnt);
      nx_enable = 1'b0;
      step();
      t0 = tick_cnt;
      repeat (300) step();
      chk("enable_off_ticks", tick_cnt - t0, 0);
      chk("enable_off_frame_done", frame_cnt, (fc0 + 1) % 10);
      nx_enable = 1'b1;

      // Divisor change with count at 100
      nx_div = 8'd0;
      done_delay = 8;
      for (int i = 0; i < 400 && (cyc + 1 - anchor) != 100; i++) step();
      nx_div = 8'd3;
      step();
      chk("div_change_tick", sample_tick, 1);
      t0 = cyc;
      for (int i = 0; i < 100 && last_tick == t0; i++) step();
      chk("div_change_period", last_tick - t0, 49);

      // Frame count wrap
      nx_div = 8'd2;
      saw_wrap = 1'b0;
      for (int i = 0; i < 1000 && !saw_wrap; i++) step();
      chk("frame_wrap", saw_wrap, 1);

      // Reset while in the right-channel wait
      done_delay = 30;
      for (int i = 0; i < 300 && !(m_busy && !m_start && m_chan); i++) step();
      chk("reached_wait_r", ser_if.ser_chan, 1);
      nx_reset = 1'b1;
      step();
      nx_reset = 1'b0;
      step();
      chk("reset_start_low", ser_if.ser_start, 0);
      chk("reset_frame_cnt", frame_cnt, 0);

      // Randomized traffic
      rand_ser = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) nx_div = 8'($urandom_range(1, 6));
         nx_clr   = ($urandom_range(0, 15) == 0);
         nx_reset = ($urandom_range(0, 1999) == 0);
         if ($urandom_range(0, 499) == 0) nx_enable = !nx_enable;
         step();
      end
      nx_clr    = 1'b0;
      nx_reset  = 1'b0;
      nx_enable = 1'b1;
      rand_ser  = 1'b0;

`ifdef AUDIO_SCHED_WDOG_EN
      // Withheld done: watchdog aborts the frame
      nx_div = 8'd2;
      done_delay = 100000;
      for (int i = 0; i < 2 * int'(WDOG_CYC) + 200 && wdog_err !== 1'b1; i++) step();
      chk("wdog_err_set", wdog_err, 1);
      step();
      chk("wdog_idle_start", ser_if.ser_start, 0);
`endif
      repeat (20) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "bench did not finish");
   end

endmodule
